// File: rtl/cp0.sv
// CP0 coprocessor: Count/Compare timer, Status, Cause and EPC registers,
// exception entry/return sequencing and the timer interrupt request.
module cp0 (
    input  logic        clk,
    input  logic        reset,
    input  logic        mfc0,
    input  logic        mtc0,
    input  logic [31:0] pc,
    input  logic [4:0]  rd,
    input  logic [31:0] wdata,
    input  logic        exception,
    input  logic        eret,
    input  logic [4:0]  cause,
    output logic [31:0] rdata,
    output logic [31:0] status,
    output logic [31:0] exc_addr,
    output logic        irq
);

    localparam logic [4:0]  RD_COUNT   = 5'd9;
    localparam logic [4:0]  RD_COMPARE = 5'd11;
    localparam logic [4:0]  RD_STATUS  = 5'd12;
    localparam logic [4:0]  RD_CAUSE   = 5'd13;
    localparam logic [4:0]  RD_EPC     = 5'd14;
    localparam logic [31:0] EXC_VECTOR = 32'h0040_0004;

    logic [31:0] count_q,    count_d;
    logic [31:0] compare_q,  compare_d;
    logic [31:0] status_q,   status_d;
    logic [31:0] epc_q,      epc_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [1:0]  ip_sw_q,    ip_sw_d;
    logic        ip7_q,      ip7_d;
    logic [31:0] cause_val;

    // Cause only stores its live fields; every other bit is hard-wired to 0.
    assign cause_val = {16'b0, ip7_q, 5'b0, ip_sw_q, 1'b0, exc_code_q, 2'b0};

    // Next-state: exception beats eret beats mtc0; a dropped request does nothing.
    always_comb begin
        count_d    = count_q + 32'd1;
        compare_d  = compare_q;
        status_d   = status_q;
        epc_d      = epc_q;
        exc_code_d = exc_code_q;
        ip_sw_d    = ip_sw_q;
        // Timer match observed this cycle raises IP7 at the edge; only a Compare write clears it.
        ip7_d      = ip7_q | (count_q == compare_q);
        if (exception) begin
            epc_d      = pc;
            exc_code_d = cause;
            status_d   = {status_q[26:0], 5'b0};
        end else if (eret) begin
            status_d   = {5'b0, status_q[31:5]};
        end else if (mtc0) begin
            case (rd)
                RD_COUNT:   count_d  = wdata;
                RD_COMPARE: begin
                    compare_d = wdata;
                    ip7_d     = 1'b0;
                end
                RD_STATUS:  status_d = wdata;
                RD_CAUSE:   ip_sw_d  = wdata[9:8];
                RD_EPC:     epc_d    = wdata;
                default:    ;
            endcase
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            compare_q  <= '0;
            status_q   <= '0;
            epc_q      <= '0;
            exc_code_q <= '0;
            ip_sw_q    <= '0;
            ip7_q      <= 1'b0;
        end else begin
            count_q    <= count_d;
            compare_q  <= compare_d;
            status_q   <= status_d;
            epc_q      <= epc_d;
            exc_code_q <= exc_code_d;
            ip_sw_q    <= ip_sw_d;
            ip7_q      <= ip7_d;
        end
    end

    // Combinational mfc0 read port; unimplemented registers read 0.
    always_comb begin
        rdata = 32'b0;
        if (mfc0) begin
            case (rd)
                RD_COUNT:   rdata = count_q;
                RD_COMPARE: rdata = compare_q;
                RD_STATUS:  rdata = status_q;
                RD_CAUSE:   rdata = cause_val;
                RD_EPC:     rdata = epc_q;
                default:    rdata = 32'b0;
            endcase
        end
    end

    assign status   = status_q;
    assign exc_addr = eret ? epc_q : EXC_VECTOR;
    assign irq      = status_q[0] & status_q[15] & ip7_q;

endmodule

// File: tb/tb_cp0.sv
// Self-checking bench for cp0: directed scenarios followed by random traffic,
// all compared against a register-level behavioural model.
module tb_cp0;

    logic        clk = 1'b0;
    logic        reset;
    logic        mfc0, mtc0, exception, eret;
    logic [31:0] pc, wdata;
    logic [4:0]  rd, cause;
    logic [31:0] rdata, status, exc_addr;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: plain 32-bit registers, Cause kept as a full word.
    logic [31:0] m_count, m_compare, m_status, m_cause, m_epc;
    logic [31:0] dut_regs [0:31];
    logic [31:0] last_rdata;
    logic        last_irq;

    cp0 dut (
        .clk(clk), .reset(reset), .mfc0(mfc0), .mtc0(mtc0), .pc(pc), .rd(rd),
        .wdata(wdata), .exception(exception), .eret(eret), .cause(cause),
        .rdata(rdata), .status(status), .exc_addr(exc_addr), .irq(irq)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] reg_of(input logic [4:0] r);
        case (r)
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            default: return 32'b0;
        endcase
    endfunction

    task automatic model_clear();
        m_count = 0; m_compare = 0; m_status = 0; m_cause = 0; m_epc = 0;
    endtask

    // Apply one clock edge to the model using the rules of the register file.
    task automatic model_edge(input logic mt, input logic ex, input logic er,
                              input logic [4:0] r, input logic [31:0] wd,
                              input logic [31:0] pcv, input logic [4:0] cs);
        logic [31:0] nxt_count;
        nxt_count = m_count + 32'd1;
        if (m_count == m_compare) m_cause = m_cause | 32'h0000_8000;
        if (ex) begin
            m_epc    = pcv;
            m_cause  = (m_cause & ~32'h0000_007C) | ({27'b0, cs} << 2);
            m_status = m_status << 5;
        end else if (er) begin
            m_status = m_status >> 5;
        end else if (mt) begin
            case (r)
                5'd9:  nxt_count = wd;
                5'd11: begin m_compare = wd; m_cause = m_cause & ~32'h0000_8000; end
                5'd12: m_status = wd;
                5'd13: m_cause = (m_cause & ~32'h0000_0300) | (wd & 32'h0000_0300);
                5'd14: m_epc = wd;
                default: ;
            endcase
        end
        m_count = nxt_count;
    endtask

    task automatic set_idle();
        mfc0 = 0; mtc0 = 0; exception = 0; eret = 0; rd = 0; wdata = 0; pc = 0; cause = 0;
    endtask

    // One transaction: drive on the falling edge, check combinational outputs, advance the model at the rising edge.
    task automatic cycle(input logic mf, input logic mt, input logic ex, input logic er,
                         input logic [4:0] r, input logic [31:0] wd,
                         input logic [31:0] pcv, input logic [4:0] cs);
        @(negedge clk);
        mfc0 = mf; mtc0 = mt; exception = ex; eret = er; rd = r; wdata = wd; pc = pcv; cause = cs;
        #1;
        last_rdata = rdata;
        last_irq   = irq;
        $display("txn t=%0t mf=%0b mt=%0b ex=%0b er=%0b rd=%0d wd=%08h pc=%08h cs=%02h rdata=%08h st=%08h ea=%08h irq=%0b",
                 $time, mf, mt, ex, er, r, wd, pcv, cs, rdata, status, exc_addr, irq);
        chk("rdata", rdata, mf ? reg_of(r) : 32'b0);
        chk("status", status, m_status);
        chk("exc_addr", exc_addr, er ? m_epc : 32'h0040_0004);
        chk("irq", {31'b0, irq}, {31'b0, m_status[0] & m_status[15] & m_cause[15]});
        @(posedge clk);
        model_edge(mt, ex, er, r, wd, pcv, cs);
    endtask

    // Read back every implemented register plus one unimplemented one within a single low phase.
    task automatic peek();
        logic [4:0] rds [6];
        rds = '{5'd7, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14};
        @(negedge clk);
        set_idle();
        mfc0 = 1;
        foreach (rds[k]) begin
            rd = rds[k];
            #1;
            dut_regs[rds[k]] = rdata;
            chk($sformatf("peek_rd%0d", rds[k]), rdata, reg_of(rds[k]));
        end
        $display("peek t=%0t count=%08h compare=%08h status=%08h cause=%08h epc=%08h",
                 $time, dut_regs[9], dut_regs[11], dut_regs[12], dut_regs[13], dut_regs[14]);
        mfc0 = 0;
        @(posedge clk);
        model_edge(0, 0, 0, 5'd0, 32'd0, 32'd0, 5'd0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        set_idle();
        reset = 0;
        @(posedge clk);
        model_edge(0, 0, 0, 5'd0, 32'd0, 32'd0, 5'd0);
    endtask

    task automatic random_cycles(input int n);
        logic [4:0] pool [8];
        logic [4:0] r;
        logic [31:0] wd;
        pool = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd7, 5'd0, 5'd31};
        for (int i = 0; i < n; i++) begin
            r  = pool[$urandom_range(0, 7)];
            wd = $urandom;
            if (r == 5'd11 && $urandom_range(0, 2) != 0) wd = m_count + 32'($urandom_range(1, 4));
            if (r == 5'd9 && $urandom_range(0, 3) == 0) wd = 32'hFFFF_FFFD;
            cycle($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                  r, wd, $urandom, 5'($urandom));
            if (i % 16 == 15) peek();
        end
    endtask

    initial begin
        bit seen5;
        set_idle();
        reset = 1;
        model_clear();
        mfc0 = 1; rd = 5'd12;
        #3;
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_status", status, 32'h0);
        chk("reset_exc_addr", exc_addr, 32'h0040_0004);
        chk("reset_irq", {31'b0, irq}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        release_reset();

        // Timer interrupt: Compare=5, Count=0, Status=0x8001.
        cycle(0, 1, 0, 0, 5'd11, 32'd5, 0, 0);
        cycle(0, 1, 0, 0, 5'd9, 32'd0, 0, 0);
        cycle(0, 1, 0, 0, 5'd12, 32'h0000_8001, 0, 0);
        seen5 = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(1, 0, 0, 0, 5'd9, 0, 0, 0);
            if (seen5) begin
                chk("timer_irq_after", {31'b0, last_irq}, 32'd1);
                break;
            end
            if (last_rdata == 32'd5) begin
                chk("timer_irq_at_match", {31'b0, last_irq}, 32'd0);
                seen5 = 1;
            end
        end
        chk("timer_match_seen", {31'b0, seen5}, 32'd1);
        cycle(0, 1, 0, 0, 5'd11, 32'd100, 0, 0);
        cycle(0, 0, 0, 0, 5'd0, 0, 0, 0);
        chk("timer_irq_cleared", {31'b0, last_irq}, 32'd0);

        // Status write and readback.
        cycle(0, 1, 0, 0, 5'd12, 32'h0000_0001, 0, 0);
        peek();
        chk("st_rd12", dut_regs[12], 32'h0000_0001);
        chk("st_rd7", dut_regs[7], 32'h0);

        // Exception entry, then eret.
        cycle(0, 0, 1, 0, 5'd0, 0, 32'h0040_0020, 5'b01000);
        peek();
        chk("exc_epc", dut_regs[14], 32'h0040_0020);
        chk("exc_cause_code", dut_regs[13] & 32'h0000_7FFF, 32'h0000_0020);
        chk("exc_status", dut_regs[12], 32'h0000_0020);
        cycle(0, 0, 0, 1, 5'd0, 0, 0, 0);
        peek();
        chk("eret_status", dut_regs[12], 32'h0000_0001);

        // Collision: exception wins over eret and mtc0.
        cycle(0, 1, 1, 1, 5'd14, 32'hDEAD_BEEF, 32'h0040_0100, 5'b01001);
        peek();
        chk("coll_epc", dut_regs[14], 32'h0040_0100);
        chk("coll_status", dut_regs[12], 32'h0000_0020);

        // Back-to-back exceptions keep shifting Status.
        cycle(0, 1, 0, 0, 5'd12, 32'hFFFF_FFFF, 0, 0);
        cycle(0, 0, 1, 0, 5'd0, 0, 32'h0040_0200, 5'b01101);
        cycle(0, 0, 1, 0, 5'd0, 0, 32'h0040_0300, 5'b01000);
        peek();
        chk("b2b_status", dut_regs[12], 32'hFFFF_FC00);
        chk("b2b_epc", dut_regs[14], 32'h0040_0300);

        random_cycles(300);

        // Asynchronous reset mid-cycle with pending requests.
        @(negedge clk);
        mfc0 = 1; mtc0 = 1; exception = 1; eret = 0; rd = 5'd12; wdata = 32'hFFFF_FFFF; pc = 32'h1234_5678; cause = 5'd9;
        #2;
        reset = 1;
        #1;
        model_clear();
        mtc0 = 0; exception = 0;
        for (int r = 9; r <= 14; r++) begin
            rd = 5'(r);
            #1;
            chk($sformatf("async_rd%0d", r), rdata, 32'h0);
        end
        chk("async_status", status, 32'h0);
        chk("async_exc_addr", exc_addr, 32'h0040_0004);
        chk("async_irq", {31'b0, irq}, 32'h0);
        @(posedge clk);
        release_reset();
        peek();
        random_cycles(80);
        peek();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cp0.md
CP0 -- requirements
Module: cp0

Interface
REQ-001 SHALL have port `clk`, input, 1 bit: the single clock; all state updates occur on the rising edge.
REQ-002 SHALL have port `reset`, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port `mfc0`, input, 1 bit: read request for CP0 register `rd`.
REQ-004 SHALL have port `mtc0`, input, 1 bit: write `wdata` into CP0 register `rd`.
REQ-005 SHALL have port `pc`, input, 32 bits: address of the trapping instruction.
REQ-006 SHALL have port `rd`, input, 5 bits: CP0 register number.
REQ-007 SHALL have port `wdata`, input, 32 bits: mtc0 write data.
REQ-008 SHALL have port `exception`, input, 1 bit: trap request.
REQ-009 SHALL have port `eret`, input, 1 bit: exception-return request.
REQ-010 SHALL have port `cause`, input, 5 bits: exception code (01000 syscall, 01001 break, 01101 teq).
REQ-011 SHALL have port `rdata`, output, 32 bits: mfc0 read data.
REQ-012 SHALL have port `status`, output, 32 bits: the current Status register.
REQ-013 SHALL have port `exc_addr`, output, 32 bits: PC redirect target.
REQ-014 SHALL have port `irq`, output, 1 bit: timer interrupt request.

Function
REQ-015 SHALL implement these registers: Count (9), Compare (11), Status (12), Cause (13), EPC (14).
- Any other `rd` SHALL read 0.
- Writes to any other `rd` SHALL be ignored.
REQ-016 `rdata` SHALL be combinational: register[`rd`] while `mfc0`=1, otherwise 0.
REQ-017 Every register SHALL be 32-bit; writes SHALL be honoured per field as follows.
- Status: fully writable.
- EPC: fully writable.
- Count: fully writable.
- Compare: fully writable.
- Cause: only bits [9:8] writable by mtc0.
- Cause[6:2] holds ExcCode; Cause[15] holds IP7.
- All other Cause bits SHALL always read 0.
REQ-018 Exception (`exception`=1 at an edge) SHALL update three registers.
- EPC <= `pc`.
- Cause[6:2] <= `cause`.
- Status <= {Status[26:0], 5'b0}, i.e. shifted left by 5, masking interrupts.
REQ-019 Eret (`eret`=1 at an edge, `exception`=0) SHALL update Status <= {5'b0, Status[31:5]}, i.e. shifted right by 5, restoring it.
REQ-020 `exc_addr` SHALL be combinational: EPC while `eret`=1, otherwise the constant 0x00400004.
REQ-021 Priority within one edge SHALL be `exception` > `eret` > `mtc0`.
- A lower-priority request asserted together with a higher one is dropped entirely.
- An mtc0 dropped this way has no effect on any register, including Count and Compare.
REQ-022 Count SHALL increment by 1 on every edge and wrap from 0xFFFFFFFF to 0.
- An mtc0 to Count loads `wdata` instead of incrementing on that edge.
REQ-023 IP7 (Cause[15]) SHALL be set at the edge following any cycle in which Count == Compare.
- An mtc0 to Compare clears IP7 and takes precedence over setting it on the same edge.
REQ-024 IP7 SHALL otherwise hold its value.
- An exception SHALL NOT clear IP7.
- An mtc0 to Cause SHALL NOT change IP7.
REQ-025 `irq` SHALL be combinational: Status[0] & Status[15] & Cause[15].
REQ-026 `status` SHALL continuously mirror the Status register.
REQ-027 Back-to-back exceptions (no eret between them) SHALL each shift Status again.
- Bits shifted out are lost; there is no saturation.
- EPC is overwritten by the later exception.

Reset
REQ-028 `reset`=1 SHALL asynchronously force Count, Compare, Status, Cause and EPC to 0, regardless of `clk`.
REQ-029 During and immediately after reset the outputs SHALL be:
- `rdata`=0;
- `status`=0;
- `exc_addr`=0x00400004;
- `irq`=0.
REQ-030 Reset asserted mid-operation SHALL discard any same-cycle exception, eret or mtc0.
- The first edge after deassertion SHALL behave as a normal cycle.

Verification
REQ-031 Status write and readback: reset, then mtc0 rd=12 wdata=0x00000001 -> after the edge, mfc0 rd=12 gives `rdata`=0x00000001 and `status`=0x00000001; mfc0 rd=7 gives 0.
REQ-032 Exception: Status=0x00000001, exception with pc=0x00400020, cause=01000 -> after the edge EPC=0x00400020, Cause=0x00000020, Status=0x00000020, `exc_addr`=0x00400004.
REQ-033 Eret following REQ-032: assert eret -> `exc_addr`=0x00400020 in the same cycle; after the edge Status=0x00000001.
REQ-034 Collision: exception together with mtc0 rd=14 wdata=0xDEADBEEF and eret -> EPC=`pc`, Status shifted left; the write and the eret have no effect.
REQ-035 Timer: mtc0 Compare=5, then Count=0, then Status=0x00008001 -> `irq`=1 exactly one edge after Count reads 5; a later mtc0 Compare=100 drops `irq` to 0 after that edge.
REQ-036 Asynchronous reset: assert `reset` between clock edges while the state is non-zero -> all registers read 0 immediately and `exc_addr`=0x00400004 without waiting for a clock edge.
